// File: rtl/regs_sb.sv
// Integer register file with a per-register busy/tag scoreboard.
// Combinational read ports see same-cycle committing write-backs; stale-tag write-backs are dropped.
module regs_sb #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int TAGW    = 3,
    parameter int X0_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NRD*AW-1:0]     raddr_i,
    output logic [NRD*XLEN-1:0]   rdata_o,
    output logic [NRD-1:0]        rready_o,
    input  logic                  iss_valid_i,
    input  logic [AW-1:0]         iss_rd_i,
    input  logic [TAGW-1:0]       iss_tag_i,
    input  logic [NWR-1:0]        wen_i,
    input  logic [NWR*AW-1:0]     waddr_i,
    input  logic [NWR*XLEN-1:0]   wdata_i,
    input  logic [NWR*TAGW-1:0]   wtag_i,
    input  logic                  flush_i,
    output logic [NREG-1:0]       busy_o
);

    localparam logic [AW:0] NREG_LIM = (AW+1)'(NREG);

    logic [XLEN-1:0] x_q   [NREG];
    logic [TAGW-1:0] tag_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NWR-1:0]  commit;

    // True for a real, writable register: in range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREG_LIM) && !((X0_ZERO != 0) && (a == '0));
    endfunction

    // Tag match uses the pre-edge tag; an idle register accepts any writer.
    always_comb begin
        commit = '0;
        for (int j = 0; j < NWR; j++) begin
            commit[j] = wen_i[j] && addr_ok(waddr_i[j*AW +: AW]) &&
                        (!busy_q[waddr_i[j*AW +: AW]] ||
                         (tag_q[waddr_i[j*AW +: AW]] == wtag_i[j*TAGW +: TAGW]));
        end
    end

    // Ascending scan so the highest committing port wins the bypass.
    always_comb begin
        rdata_o  = '0;
        rready_o = '0;
        if (rstn) begin
            for (int k = 0; k < NRD; k++) begin
                if (!addr_ok(raddr_i[k*AW +: AW])) begin
                    rready_o[k] = 1'b1;
                end else begin
                    rdata_o[k*XLEN +: XLEN] = x_q[raddr_i[k*AW +: AW]];
                    rready_o[k]             = !busy_q[raddr_i[k*AW +: AW]];
                    for (int j = 0; j < NWR; j++) begin
                        if (commit[j] && (waddr_i[j*AW +: AW] == raddr_i[k*AW +: AW])) begin
                            rdata_o[k*XLEN +: XLEN] = wdata_i[j*XLEN +: XLEN];
                            rready_o[k]             = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Later non-blocking assignments take precedence: high write port, then flush, then issue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                x_q[i]   <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (commit[j]) begin
                    x_q[waddr_i[j*AW +: AW]]    <= wdata_i[j*XLEN +: XLEN];
                    busy_q[waddr_i[j*AW +: AW]] <= 1'b0;
                end
            end
            if (flush_i) begin
                busy_q <= '0;
            end
            if (iss_valid_i && addr_ok(iss_rd_i)) begin
                busy_q[iss_rd_i] <= 1'b1;
                tag_q[iss_rd_i]  <= iss_tag_i;
            end
        end
    end

    assign busy_o = busy_q;

endmodule
